// File: rtl/uart_if.sv
// ---------------------------------------------------------------------------
// uart_if: word handshake plus serial line shared by uart_tx and uart_rx.
//
// Members:
//   data  [DATA_WIDTH]  payload word
//   valid               word on data is available
//   ready               consumer can accept a word
//   sig                 serial line (idles high)
//
// Modports:
//   master  word producer (drives data/valid, observes ready/sig)
//   slave   word consumer (uart_tx side: takes data/valid, drives ready/sig)
// ---------------------------------------------------------------------------
interface uart_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  sig;

    modport master (output data, output valid, input ready, input sig);
    modport slave  (input data, input valid, output ready, output sig);
endinterface

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx: UART transmitter. Accepts one DATA_WIDTH word per valid/ready
// handshake and serialises it as start bit, data LSB first, optional even
// parity bit, then STOP_BITS stop bits. Every line bit lasts
// PULSE_WIDTH = CLK_FREQ / BAUD_RATE clock cycles.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   txif.data   word to send, sampled on handshake
//   txif.valid  word available
//   txif.ready  transmitter idle and able to accept a word
//   txif.sig    serial line, idles high, driven directly from a flop
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> PARITY state (even parity over the data bits) between
//                DATA and STOP
//   undefined -> no parity state, logic or flop
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int STOP_BITS  = 1
) (
    input  logic  clk,
    input  logic  rst,
    uart_if.slave txif
);
    localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W       = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    // Index is shared between data bits and stop bits.
    localparam int IDX_W       = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  sig_q, sig_d;
    logic                  ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic                  bit_done;
    logic [DATA_WIDTH-1:0] shreg_next;

    assign bit_done   = (cnt_q == CNT_LAST);
    assign shreg_next = shreg_q >> 1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        sig_d    = sig_q;
        ready_d  = ready_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        // Bit-time counter runs in every non-idle state and restarts per bit.
        if (state_q != IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                sig_d = 1'b1;
                cnt_d = '0;
                if (!ready_q) begin
                    // First edge after reset release: become ready.
                    ready_d = 1'b1;
                end else if (txif.valid) begin
                    ready_d  = 1'b0;
                    state_d  = START;
                    sig_d    = 1'b0;
                    shreg_d  = txif.data;
                    idx_d    = '0;
`ifdef UART_TX_PARITY_EN
                    // Even parity of the word, captured with it.
                    parity_d = ^txif.data;
`endif
                end
            end

            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    sig_d   = shreg_q[0];
                    idx_d   = '0;
                end
            end

            DATA: begin
                if (bit_done) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        sig_d   = parity_q;
`else
                        state_d = STOP;
                        sig_d   = 1'b1;
`endif
                    end else begin
                        // Line flop loads the bit that becomes LSB after the shift.
                        shreg_d = shreg_next;
                        sig_d   = shreg_next[0];
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    sig_d   = 1'b1;
                    idx_d   = '0;
                end
            end
`endif

            STOP: begin
                sig_d = 1'b1;
                if (bit_done) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                sig_d   = 1'b1;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            sig_q    <= 1'b1;
            ready_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            sig_q    <= sig_d;
            ready_q  <= ready_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign txif.sig   = sig_q;
    assign txif.ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx: self-checking bench for uart_tx. A small bit rate divider
// (PULSE_WIDTH = 1_150_000 / 115200 = 9) keeps frames short. The expected
// line waveform is built from the frame format: a list of bit values, each
// held PULSE_WIDTH cycles, compared cycle by cycle after each handshake.
// ---------------------------------------------------------------------------
module tb_uart_tx;
    localparam int DW        = 8;
    localparam int BAUD      = 115200;
    localparam int CLK_FREQ  = 1_150_000;
    localparam int STOP_BITS = 1;
    localparam int PW        = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_BITS = 1 + DW + PBITS + STOP_BITS;
    localparam int FRAME_CYC  = FRAME_BITS * PW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_if #(.DATA_WIDTH(DW)) txif ();

    uart_tx #(
        .DATA_WIDTH(DW),
        .BAUD_RATE (BAUD),
        .CLK_FREQ  (CLK_FREQ),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .txif(txif)
    );

    int checks = 0;
    int errs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Value of line bit k of the frame carrying word w.
    function automatic logic frame_bit(input logic [7:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= DW) return w[k-1];
        if (PBITS == 1 && k == DW + 1) return logic'($countones(w) % 2);
        return 1'b1;
    endfunction

    task automatic idle_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({tag, "_sig"}, txif.sig, 1'b1);
            check({tag, "_ready"}, txif.ready, 1'b1);
        end
    endtask

    // Called at a negedge. Presents w, waits for ready, then checks the whole
    // frame. hold keeps valid high with next_w for a back-to-back frame.
    // inj_n pulses valid with 0xA3 at that cycle of the frame; abort_n asserts
    // reset at that cycle and ends the frame there.
    task automatic send(input logic [7:0] w, input bit hold, input logic [7:0] next_w,
                        input int inj_n, input int abort_n, output int waited);
        logic exp_sig;
        txif.data  = w;
        txif.valid = 1'b1;
        waited     = 0;
        while (txif.ready !== 1'b1) begin
            @(negedge clk);
            waited++;
            if (waited > 5 * FRAME_CYC) begin
                check("ready_timeout", 32'd0, 32'd1);
                txif.valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (hold) txif.data = next_w;
        else txif.valid = 1'b0;
        for (int n = 0; n <= FRAME_CYC; n++) begin
            if (n > 0) @(negedge clk);
            if (n == abort_n) begin
                #1 rst = 1'b1;
                #1;
                check("rst_async_sig", txif.sig, 1'b1);
                check("rst_async_ready", txif.ready, 1'b0);
                @(negedge clk);
                check("rst_hold_sig", txif.sig, 1'b1);
                check("rst_hold_ready", txif.ready, 1'b0);
                rst = 1'b0;
                @(negedge clk);
                check("rst_release_ready", txif.ready, 1'b1);
                check("rst_release_sig", txif.sig, 1'b1);
                return;
            end
            if (n == inj_n) begin
                txif.valid = 1'b1;
                txif.data  = 8'hA3;
            end
            if (n == inj_n + 1) txif.valid = 1'b0;
            exp_sig = (n < FRAME_CYC) ? frame_bit(w, n / PW) : 1'b1;
            check($sformatf("sig w=%02h n=%0d", w, n), txif.sig, exp_sig);
            check($sformatf("ready w=%02h n=%0d", w, n), txif.ready, (n == FRAME_CYC));
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         wt;
        logic [7:0] cur, nxt;
        bit         h, prev_h;

        rst        = 1'b1;
        txif.valid = 1'b0;
        txif.data  = '0;
        #1;
        check("reset_sig", txif.sig, 1'b1);
        check("reset_ready", txif.ready, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_hold_ready", txif.ready, 1'b0);
        check("reset_hold_sig", txif.sig, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("release_ready", txif.ready, 1'b1);

        // Single frame
        send(8'h55, 1'b0, 8'h00, -1, -1, wt);
        check("single_wait", wt, 0);
        idle_check("idle1", 3);

        // Back-to-back with valid held
        send(8'h00, 1'b1, 8'hFF, -1, -1, wt);
        send(8'hFF, 1'b0, 8'h00, -1, -1, wt);
        check("b2b_wait", wt, 0);
        idle_check("idle2", 2);

        // Valid pulse while busy is dropped
        send(8'h3C, 1'b0, 8'h00, 4 * PW + 3, -1, wt);
        idle_check("busy_drop", FRAME_CYC + 5);

        // Reset during data bit 3, then a fresh frame
        send(8'h0F, 1'b0, 8'h00, -1, 4 * PW + PW / 2, wt);
        idle_check("post_abort", 2 * PW);
        send(8'h81, 1'b0, 8'h00, -1, -1, wt);
        // Reset during the start bit (line low)
        send(8'hF0, 1'b0, 8'h00, -1, 2, wt);
        idle_check("post_abort2", 2 * PW);

`ifdef UART_TX_PARITY_EN
        send(8'h07, 1'b0, 8'h00, -1, -1, wt);
        send(8'h03, 1'b0, 8'h00, -1, -1, wt);
`endif

        // Randomized words, gaps and back-to-back runs
        prev_h = 1'b0;
        cur    = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            nxt = 8'($urandom);
            h   = 1'($urandom_range(0, 1));
            send(cur, h, nxt, -1, -1, wt);
            if (prev_h) check($sformatf("rand_b2b_wait %0d", i), wt, 0);
            if (!h) idle_check("rand_gap", $urandom_range(0, 3));
            prev_h = h;
            cur    = nxt;
        end
        if (prev_h) begin
            send(cur, 1'b0, 8'h00, -1, -1, wt);
            check("rand_b2b_last", wt, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
